multiplier_pipe: RTL and testbench

MULTIPLIER_PIPE -- requirements
Module: multiplier_pipe

---
 rtl/multiplier_pipe.sv | 110 +++++++++++
 tb/tb_multiplier_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_pipe
//  Description : Pipelined W x W -> 2W multiplier for signed or unsigned
//                operands. Stage 1 captures the operands, stage 2 holds W
//                partial products, and the remaining stages reduce them
//                with a pairwise adder tree. A single stall signal freezes
//                every stage when the output is not being accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_pipe #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_val,
  output logic           in_rdy,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_sgn,
  output logic           out_val,
  input  logic           out_rdy,
  output logic [2*W-1:0] out_prod,
  output logic           busy
);

  localparam int LOGW = $clog2(W);
  localparam int LAT  = 2 + LOGW;
  localparam int PW   = 2 * W;

  // Stage 1: captured operands and their signedness.
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sgn_q;

  // Valid bit per stage: [1] operands, [2] partial products, [3..LAT] tree.
  logic [LAT:1]  vld_q;

  // Level 0 holds the partial products; level j holds W>>j sums.
  // Entries beyond a level's population stay at zero.
  logic [PW-1:0] lvl_q [LOGW+1][W];
  logic [PW-1:0] lvl_d [LOGW+1][W];

  logic          stall;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] row;

  assign stall    = vld_q[LAT] & ~out_rdy;
  assign in_rdy   = ~stall;
  assign out_val  = vld_q[LAT];
  assign out_prod = lvl_q[LOGW][0];
  assign busy     = |vld_q;

  // Partial-product generation and one adder-tree level per stage.
  always_comb begin
    a_ext = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    row   = '0;
    for (int i = 0; i < W; i++) begin
      row = a_ext << i;
      // For two's-complement multipliers the top bit of b carries weight
      // -2^(W-1), so its row is negated; this makes the 2W-bit sum the
      // exact signed product without extending b beyond W bits.
      if (sgn_q && (i == W - 1)) begin
        row = -row;
      end
      lvl_d[0][i] = b_q[i] ? row : '0;
    end
    for (int j = 1; j <= LOGW; j++) begin
      for (int k = 0; k < W; k++) begin
        lvl_d[j][k] = '0;
        if (k < (W >> j)) begin
          lvl_d[j][k] = lvl_q[j-1][2*k] + lvl_q[j-1][2*k+1];
        end
      end
    end
  end

  // Pipeline registers: freeze on stall, otherwise advance one stage.
  // Data only loads behind a valid bit so bubbles leave the last product
  // in place at the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      vld_q <= '0;
      for (int j = 0; j <= LOGW; j++) begin
        for (int k = 0; k < W; k++) begin
          lvl_q[j][k] <= '0;
        end
      end
    end else if (!stall) begin
      vld_q <= {vld_q[LAT-1:1], in_val};
      if (in_val) begin
        a_q   <= in_a;
        b_q   <= in_b;
        sgn_q <= in_sgn;
      end
      for (int j = 0; j <= LOGW; j++) begin
        if (vld_q[j+1]) begin
          for (int k = 0; k < W; k++) begin
            lvl_q[j][k] <= lvl_d[j][k];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_pipe
//  Description : Directed, self-checking bench for multiplier_pipe with a
//                W=8 instance and a W=16 instance checked against a
//                behavioural product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_sgn = 1'b0;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [15:0] out_prod;
  logic        busy;

  logic        in_val16 = 1'b0;
  logic        in_rdy16;
  logic [15:0] in_a16 = '0;
  logic [15:0] in_b16 = '0;
  logic        in_sgn16 = 1'b0;
  logic        out_val16;
  logic        out_rdy16 = 1'b1;
  logic [31:0] out_prod16;
  logic        busy16;

  int n_checks = 0;
  int n_fail   = 0;

  multiplier_pipe #(.W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sgn   (in_sgn),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_prod (out_prod),
    .busy     (busy)
  );

  multiplier_pipe #(.W(16)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val16),
    .in_rdy   (in_rdy16),
    .in_a     (in_a16),
    .in_b     (in_b16),
    .in_sgn   (in_sgn16),
    .out_val  (out_val16),
    .out_rdy  (out_rdy16),
    .out_prod (out_prod16),
    .busy     (busy16)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_val = 1'b1; in_a = 8'h12; in_b = 8'h34; out_rdy = 1'b1;
    repeat (3) tick();
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got %b want 0", out_val); end
    n_checks++; if (out_prod !== 16'h0000) begin n_fail++; $display("FAIL reset_out_prod got %h want 0000", out_prod); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    n_checks++; if (out_val16 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_w16 got val=%b busy=%b want 0/0", out_val16, busy16); end
    in_val = 1'b0;
    rst = 1'b0;
  endtask

  // First edge after release must accept; result visible after edge k+4 only.
  task automatic test_latency();
    in_val = 1'b1; in_a = 8'h80; in_b = 8'h80; in_sgn = 1'b1; out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy got %b want 1", busy); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL lat_early edge+0 got %b want 0", out_val); end
    for (int e = 1; e < 4; e++) begin
      tick();
      n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL lat_early edge+%0d got %b want 0", e, out_val); end
    end
    tick();
    n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL lat_val edge+4 got %b want 1", out_val); end
    n_checks++; if (out_prod !== 16'h4000) begin n_fail++; $display("FAIL lat_prod got %h want 4000", out_prod); end
    tick();
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL lat_after got %b want 0", out_val); end
  endtask

  task automatic test_sign_mix();
    logic [7:0]  sa [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  sb [4] = '{8'h02, 8'h02, 8'hFF, 8'hFF};
    logic        ss [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] se [4] = '{16'hFFFE, 16'h01FE, 16'hFE01, 16'h0001};
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_a = sa[i]; in_b = sb[i]; in_sgn = ss[i];
      tick();
    end
    in_val = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_val !== 1'b1 || out_prod !== se[i]) begin n_fail++; $display("FAIL sign_mix[%0d] got val=%b prod=%h want 1/%h", i, out_val, out_prod, se[i]); end
      tick();
    end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL sign_mix_end got %b want 0", out_val); end
  endtask

  // Six back-to-back operands; consumer refuses for 3 cycles at first result.
  task automatic test_stall();
    logic [7:0]  va [6] = '{8'h03, 8'h10, 8'hFF, 8'h12, 8'hAB, 8'h80};
    logic [7:0]  vb [6] = '{8'h05, 8'h10, 8'h01, 8'h34, 8'h02, 8'h03};
    logic [15:0] ve [6] = '{16'h000F, 16'h0100, 16'h00FF, 16'h03A8, 16'h0156, 16'h0180};
    int idx = 0;
    int got = 0;
    int stall_left = 3;
    logic first_seen = 1'b0;
    in_sgn = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_val = (idx < 6);
      if (idx < 6) begin in_a = va[idx]; in_b = vb[idx]; end
      if (out_val) first_seen = 1'b1;
      out_rdy = !(first_seen && stall_left > 0);
      #1;
      if (!out_rdy) begin
        stall_left--;
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_in_rdy got %b want 0", in_rdy); end
        n_checks++; if (out_val !== 1'b1 || out_prod !== ve[0]) begin n_fail++; $display("FAIL stall_hold got val=%b prod=%h want 1/%h", out_val, out_prod, ve[0]); end
      end
      if (out_val && out_rdy) begin
        n_checks++; if (out_prod !== ve[got]) begin n_fail++; $display("FAIL stall_order[%0d] got %h want %h", got, out_prod, ve[got]); end
        got++;
      end
      if (in_val && in_rdy) idx++;
      tick();
    end
    in_val = 1'b0; out_rdy = 1'b1;
    n_checks++; if (got !== 6 || idx !== 6) begin n_fail++; $display("FAIL stall_count got results=%0d sent=%0d want 6/6", got, idx); end
    repeat (6) tick();
    n_checks++; if (out_val !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_drain got val=%b busy=%b want 0/0", out_val, busy); end
  endtask

  // in_val 1,0,1 -> results keep the gap; busy drops after last consume.
  task automatic test_bubble();
    out_rdy = 1'b1;
    in_val = 1'b1; in_a = 8'h07; in_b = 8'h06; in_sgn = 1'b0;
    tick();
    in_val = 1'b0;
    tick();
    in_val = 1'b1; in_a = 8'hFE; in_b = 8'h03; in_sgn = 1'b1;
    tick();
    in_val = 1'b0;
    tick();
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL bubble_k3 got %b want 0", out_val); end
    tick();
    n_checks++; if (out_val !== 1'b1 || out_prod !== 16'h002A) begin n_fail++; $display("FAIL bubble_first got val=%b prod=%h want 1/002A", out_val, out_prod); end
    tick();
    n_checks++; if (out_val !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bubble_gap got val=%b busy=%b want 0/1", out_val, busy); end
    tick();
    n_checks++; if (out_val !== 1'b1 || out_prod !== 16'hFFFA) begin n_fail++; $display("FAIL bubble_second got val=%b prod=%h want 1/FFFA", out_val, out_prod); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bubble_busy_last got %b want 1", busy); end
    tick();
    n_checks++; if (out_val !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bubble_busy_fall got val=%b busy=%b want 0/0", out_val, busy); end
  endtask

  // Reset with three transactions in flight must discard them immediately.
  task automatic test_reset_flush();
    int stale = 0;
    out_rdy = 1'b1; in_sgn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1; in_a = 8'h11 + 8'(i); in_b = 8'h05;
      tick();
    end
    in_val = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_val !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_async got val=%b busy=%b want 0/0", out_val, busy); end
    n_checks++; if (in_rdy !== 1'b1 || out_prod !== 16'h0000) begin n_fail++; $display("FAIL flush_state got rdy=%b prod=%h want 1/0000", in_rdy, out_prod); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_val !== 1'b0 || busy !== 1'b0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL flush_stale got %0d stale cycles want 0", stale); end
  endtask

  // W=16 instance: corner products then random operands, random back-pressure.
  task automatic test_w16_random();
    localparam int N = 40;
    logic [15:0] ra [N];
    logic [15:0] rb [N];
    logic        rs [N];
    logic [31:0] re [N];
    logic [31:0] q [$];
    logic [31:0] exp_v;
    int sent = 0;
    int got = 0;
    int extra = 0;
    ra[0] = 16'h8000; rb[0] = 16'h8000; rs[0] = 1'b1;
    ra[1] = 16'hFFFF; rb[1] = 16'hFFFF; rs[1] = 1'b0;
    ra[2] = 16'hFFFF; rb[2] = 16'hFFFF; rs[2] = 1'b1;
    for (int i = 3; i < N; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < N; i++) begin
      if (rs[i])
        re[i] = $signed({{16{ra[i][15]}}, ra[i]}) * $signed({{16{rb[i][15]}}, rb[i]});
      else
        re[i] = {16'h0000, ra[i]} * {16'h0000, rb[i]};
    end
    n_checks++; if (re[0] !== 32'h4000_0000 || re[1] !== 32'hFFFE_0001 || re[2] !== 32'h0000_0001) begin n_fail++; $display("FAIL w16_model_corners got %h %h %h", re[0], re[1], re[2]); end
    for (int c = 0; c < 600 && got < N; c++) begin
      in_val16 = (sent < N);
      if (sent < N) begin in_a16 = ra[sent]; in_b16 = rb[sent]; in_sgn16 = rs[sent]; end
      out_rdy16 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_val16 && out_rdy16) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w16_unexpected got %h want no result", out_prod16);
        end else begin
          exp_v = q.pop_front();
          n_checks++; if (out_prod16 !== exp_v) begin n_fail++; $display("FAIL w16_prod[%0d] got %h want %h", got, out_prod16, exp_v); end
        end
        got++;
      end
      if (in_val16 && in_rdy16) begin
        q.push_back(re[sent]);
        sent++;
      end
      tick();
    end
    in_val16 = 1'b0; out_rdy16 = 1'b1;
    n_checks++; if (got !== N || sent !== N) begin n_fail++; $display("FAIL w16_count got results=%0d sent=%0d want %0d/%0d", got, sent, N, N); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_val16) extra++;
    end
    n_checks++; if (extra !== 0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL w16_drain got extra=%0d busy=%b want 0/0", extra, busy16); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sign_mix();
    test_stall();
    test_bubble();
    test_reset_flush();
    test_w16_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
